// File: rtl/riscv_pkg.sv
// Shared pipeline constants and types for the ID, EX and WB stages.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_AW     = 5;
    localparam int CTRL_W     = 12;
    localparam int MEMRD_BIT  = 3;
    localparam int WE_BIT     = 0;
    localparam int ALU_OP_LSB = 4;
    localparam int ALU_OP_W   = 4;

    typedef logic [XLEN-1:0]   xlen_t;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef struct packed {
        logic      valid;
        xlen_t     pc;
        xlen_t     imm;
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        xlen_t     op1;
        xlen_t     op2;
        ctrl_t     ctrl;
    } id_ex_t;

    function automatic logic is_load(input ctrl_t c);
        return c[MEMRD_BIT];
    endfunction

    function automatic logic writes_reg(input ctrl_t c);
        return c[WE_BIT];
    endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// Write-through bypass for one source operand: the register file writes on the
// same edge this stage samples, so a matching WB write replaces the stale read.
module wb_bypass_mux
    import riscv_pkg::*;
(
    input  reg_addr_t rs_i,
    input  xlen_t     rf_data_i,
    input  logic      wb_we_i,
    input  reg_addr_t wb_rd_i,
    input  xlen_t     wb_wd_i,
    input  logic      stall_i,
    output xlen_t     op_o
);

    logic hit;

    // The register file drops writes while stalled, so the bypass must drop them too.
    assign hit  = wb_we_i && !stall_i && (wb_rd_i != '0) && (wb_rd_i == rs_i);
    assign op_o = hit ? wb_wd_i : rf_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB write-through bypass and load-use bubble insertion.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [XLEN-1:0]   rf_rd1_i,
    input  logic [XLEN-1:0]   rf_rd2_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_wd_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [REG_AW-1:0] ex_rs1_o,
    output logic [REG_AW-1:0] ex_rs2_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [XLEN-1:0]   ex_op1_o,
    output logic [XLEN-1:0]   ex_op2_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              hazard_stall_o
);

    id_ex_t ex_q;
    id_ex_t ex_d;
    xlen_t  op1;
    xlen_t  op2;
    logic   load_use;

    wb_bypass_mux u_byp_op1 (
        .rs_i      (id_rs1_i),
        .rf_data_i (rf_rd1_i),
        .wb_we_i   (wb_we_i),
        .wb_rd_i   (wb_rd_i),
        .wb_wd_i   (wb_wd_i),
        .stall_i   (stall_i),
        .op_o      (op1)
    );

    wb_bypass_mux u_byp_op2 (
        .rs_i      (id_rs2_i),
        .rf_data_i (rf_rd2_i),
        .wb_we_i   (wb_we_i),
        .wb_rd_i   (wb_rd_i),
        .wb_wd_i   (wb_wd_i),
        .stall_i   (stall_i),
        .op_o      (op2)
    );

    // Load result is not available until after EX; a consumer one behind must wait a cycle.
    assign load_use = ex_q.valid && is_load(ex_q.ctrl) && (ex_q.rd != '0) && id_valid_i &&
                      ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));

    always_comb begin
        ex_d = ex_q;
        if (stall_i) begin
            ex_d = ex_q;
        end else if (flush_i || load_use) begin
            ex_d = '0;
        end else begin
            ex_d.valid = id_valid_i;
            ex_d.pc    = id_pc_i;
            ex_d.imm   = id_imm_i;
            ex_d.rs1   = id_rs1_i;
            ex_d.rs2   = id_rs2_i;
            ex_d.rd    = id_rd_i;
            ex_d.op1   = op1;
            ex_d.op2   = op2;
            ex_d.ctrl  = id_valid_i ? id_ctrl_i : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid_o     = ex_q.valid;
    assign ex_pc_o        = ex_q.pc;
    assign ex_imm_o       = ex_q.imm;
    assign ex_rs1_o       = ex_q.rs1;
    assign ex_rs2_o       = ex_q.rs2;
    assign ex_rd_o        = ex_q.rd;
    assign ex_op1_o       = ex_q.op1;
    assign ex_op2_o       = ex_q.op2;
    assign ex_ctrl_o      = ex_q.ctrl;
    assign hazard_stall_o = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage; expected EX contents go through a scoreboard queue.
module tb_id_ex_stage;

    typedef enum logic [1:0] {LD, BUB, HOLD} kind_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [11:0] ctrl;
    } exp_t;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        idv;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [11:0] ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [31:0] wbwd;
        kind_e       kind;
        logic        haz;
        logic        evalid;
        logic [11:0] ectrl;
        logic [31:0] eop1;
        logic [31:0] eop2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_imm = '0, rf_rd1 = '0, rf_rd2 = '0, wb_wd = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
    logic [11:0] id_ctrl = '0;
    logic        wb_we = 1'b0;

    logic        ex_valid, hazard_stall;
    logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [11:0] ex_ctrl;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t last_exp = '0;
    vec_t vecs[$];

    id_ex_stage dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .stall_i        (stall),
        .flush_i        (flush),
        .id_valid_i     (id_valid),
        .id_pc_i        (id_pc),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_rd_i        (id_rd),
        .id_imm_i       (id_imm),
        .id_ctrl_i      (id_ctrl),
        .rf_rd1_i       (rf_rd1),
        .rf_rd2_i       (rf_rd2),
        .wb_we_i        (wb_we),
        .wb_rd_i        (wb_rd),
        .wb_wd_i        (wb_wd),
        .ex_valid_o     (ex_valid),
        .ex_pc_o        (ex_pc),
        .ex_imm_o       (ex_imm),
        .ex_rs1_o       (ex_rs1),
        .ex_rs2_o       (ex_rs2),
        .ex_rd_o        (ex_rd),
        .ex_op1_o       (ex_op1),
        .ex_op2_o       (ex_op2),
        .ex_ctrl_o      (ex_ctrl),
        .hazard_stall_o (hazard_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    task automatic v(input logic st, input logic fl, input logic idv, input logic [31:0] pc,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic [31:0] imm, input logic [11:0] ctrl, input logic [31:0] rd1,
                     input logic [31:0] rd2, input logic wbwe, input logic [4:0] wbrd,
                     input logic [31:0] wbwd, input kind_e kind, input logic haz,
                     input logic evalid, input logic [11:0] ectrl, input logic [31:0] eop1,
                     input logic [31:0] eop2);
        vec_t t;
        t.stall = st;   t.flush = fl;   t.idv = idv;   t.pc = pc;
        t.rs1 = rs1;    t.rs2 = rs2;    t.rd = rd;     t.imm = imm;
        t.ctrl = ctrl;  t.rd1 = rd1;    t.rd2 = rd2;   t.wbwe = wbwe;
        t.wbrd = wbrd;  t.wbwd = wbwd;  t.kind = kind; t.haz = haz;
        t.evalid = evalid; t.ectrl = ectrl; t.eop1 = eop1; t.eop2 = eop2;
        vecs.push_back(t);
    endtask

    task automatic check_out(input string name);
        exp_t act, exp;
        act = {ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_ctrl};
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            exp = sb_q.pop_front();
            if (act !== exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", name, act, exp);
            end
        end
    endtask

    task automatic check_haz(input string name, input logic exp);
        checks++;
        if (hazard_stall !== exp) begin
            failures++;
            $display("FAIL %s: hazard_stall got %b expected %b", name, hazard_stall, exp);
        end
    endtask

    task automatic randomize_inputs();
        stall = 1'($urandom);   flush = 1'($urandom);  id_valid = 1'($urandom);
        id_pc = $urandom;       id_imm = $urandom;     rf_rd1 = $urandom;
        rf_rd2 = $urandom;      wb_wd = $urandom;      wb_we = 1'($urandom);
        id_rs1 = 5'($urandom);  id_rs2 = 5'($urandom); id_rd = 5'($urandom);
        wb_rd = 5'($urandom);   id_ctrl = 12'($urandom);
    endtask

    initial begin
        exp_t e;
        string nm;

        // Reset with random inputs for two edges.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            randomize_inputs();
            sb_q.push_back('0);
            @(posedge clk);
            #1;
            check_out($sformatf("reset_%0d", i));
        end
        @(negedge clk);
        rst_n = 1'b1;

        v(0,0,1,'h100, 1,2,3,'h4, 'h001,'h0A,  'h0B, 0,0,'h0,        LD, 0,1,'h001,'h0A,'h0B);
        v(0,0,1,'h104, 5,6,8,'h0, 'h001,'h11,  'h22, 1,5,'hDEADBEEF, LD, 0,1,'h001,'hDEADBEEF,'h22);
        v(0,0,1,'h108, 0,6,9,'h0, 'h001,'h00,  'h33, 1,0,'hDEADBEEF, LD, 0,1,'h001,'h0,'h33);
        v(0,0,1,'h10C, 1,6,10,'h0,'h001,'h44,  'h55, 1,6,'h66,       LD, 0,1,'h001,'h44,'h66);
        v(0,0,0,'h110, 2,3,4,'h7, 'hFFF,'h01,  'h02, 0,0,'h0,        LD, 0,0,'h000,'h01,'h02);
        v(0,0,1,'h114, 1,2,7,'h10,'h009,'h1000,'h00, 0,0,'h0,        LD, 0,1,'h009,'h1000,'h0);
        v(0,0,1,'h118, 1,7,11,'h0,'h001,'h05,  'h06, 0,0,'h0,        BUB,1,0,'h000,'h0,'h0);
        v(0,0,1,'h118, 1,7,11,'h0,'h001,'h05,  'h06, 0,0,'h0,        LD, 0,1,'h001,'h05,'h06);
        v(0,0,1,'h11C, 3,4,7,'h0, 'h009,'h01,  'h02, 0,0,'h0,        LD, 0,1,'h009,'h01,'h02);
        v(0,0,0,'h120, 7,0,0,'h0, 'h000,'h00,  'h00, 0,0,'h0,        LD, 0,0,'h000,'h0,'h0);
        v(0,0,1,'h124, 1,2,0,'h0, 'h009,'h03,  'h04, 0,0,'h0,        LD, 0,1,'h009,'h03,'h04);
        v(0,0,1,'h128, 0,0,5,'h0, 'h001,'h00,  'h00, 0,0,'h0,        LD, 0,1,'h001,'h0,'h0);
        v(0,1,1,'h12C, 1,2,3,'h5, 'h001,'h09,  'h09, 0,0,'h0,        BUB,0,0,'h000,'h0,'h0);
        v(0,0,1,'h130, 1,2,9,'h0, 'h009,'h07,  'h08, 0,0,'h0,        LD, 0,1,'h009,'h07,'h08);
        v(0,0,1,'h134, 9,1,2,'h0, 'h001,'h01,  'h02, 0,0,'h0,        BUB,1,0,'h000,'h0,'h0);
        v(0,0,1,'h134, 9,1,2,'h0, 'h001,'h01,  'h02, 0,0,'h0,        LD, 0,1,'h001,'h01,'h02);
        v(0,0,1,'h138, 3,0,4,'h0, 'h001,'h00,  'h00, 1,3,'h42,       LD, 0,1,'h001,'h42,'h0);
        v(1,0,1,'h13C, 3,4,12,'h0,'h001,'h99,  'h88, 1,3,'h77,       HOLD,0,0,'h000,'h0,'h0);
        v(1,0,1,'h13C, 3,4,12,'h0,'h001,'h99,  'h88, 1,3,'h77,       HOLD,0,0,'h000,'h0,'h0);
        v(1,0,1,'h13C, 3,4,12,'h0,'h001,'h99,  'h88, 1,3,'h77,       HOLD,0,0,'h000,'h0,'h0);
        v(0,0,1,'h13C, 3,4,12,'h0,'h001,'h99,  'h88, 1,3,'h77,       LD, 0,1,'h001,'h77,'h88);
        v(1,1,1,'h140, 1,2,3,'h0, 'h001,'h01,  'h02, 0,0,'h0,        HOLD,0,0,'h000,'h0,'h0);
        v(0,1,1,'h140, 1,2,3,'h0, 'h001,'h01,  'h02, 0,0,'h0,        BUB,0,0,'h000,'h0,'h0);
        v(0,0,1,'h144, 1,2,7,'h0, 'h009,'h01,  'h02, 0,0,'h0,        LD, 0,1,'h009,'h01,'h02);
        v(1,0,1,'h148, 7,2,5,'h0, 'h001,'h03,  'h04, 0,0,'h0,        HOLD,1,0,'h000,'h0,'h0);
        v(0,0,1,'h148, 7,2,5,'h0, 'h001,'h03,  'h04, 0,0,'h0,        BUB,1,0,'h000,'h0,'h0);
        v(0,0,1,'h148, 7,2,5,'h0, 'h001,'h03,  'h04, 0,0,'h0,        LD, 0,1,'h001,'h03,'h04);

        foreach (vecs[i]) begin
            @(negedge clk);
            stall = vecs[i].stall;  flush = vecs[i].flush;  id_valid = vecs[i].idv;
            id_pc = vecs[i].pc;     id_rs1 = vecs[i].rs1;   id_rs2 = vecs[i].rs2;
            id_rd = vecs[i].rd;     id_imm = vecs[i].imm;   id_ctrl = vecs[i].ctrl;
            rf_rd1 = vecs[i].rd1;   rf_rd2 = vecs[i].rd2;   wb_we = vecs[i].wbwe;
            wb_rd = vecs[i].wbrd;   wb_wd = vecs[i].wbwd;
            case (vecs[i].kind)
                LD:      e = '{valid: vecs[i].evalid, pc: vecs[i].pc, imm: vecs[i].imm,
                               rs1: vecs[i].rs1, rs2: vecs[i].rs2, rd: vecs[i].rd,
                               op1: vecs[i].eop1, op2: vecs[i].eop2, ctrl: vecs[i].ectrl};
                BUB:     e = '0;
                default: e = last_exp;
            endcase
            last_exp = e;
            sb_q.push_back(e);
            #1;
            nm = $sformatf("vec%0d_pc%0h", i, vecs[i].pc);
            check_haz({nm, "_haz"}, vecs[i].haz);
            @(posedge clk);
            #1;
            check_out(nm);
        end

        // Reset asserted while stalled must still clear the stage.
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b1;
        id_valid = 1'b1;
        sb_q.push_back('0);
        @(posedge clk);
        #1;
        check_out("reset_mid_stall");

        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        id_valid = 1'b1;
        id_pc = 'h200; id_imm = 'h3; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd4;
        id_ctrl = 'h001; rf_rd1 = 'hAB; rf_rd2 = 'hCD; wb_we = 1'b0;
        sb_q.push_back('{valid: 1'b1, pc: 'h200, imm: 'h3, rs1: 5'd1, rs2: 5'd2, rd: 5'd4,
                         op1: 'hAB, op2: 'hCD, ctrl: 'h001});
        @(posedge clk);
        #1;
        check_out("after_reset_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
